// File: rtl/mul_op_sequencer.sv
// mul_op_sequencer: buffers operand pairs in a small FIFO and feeds them, one pair at a
// time, to an external sequential multiplier over a shared 16-bit operand bus.
// The result is held in a single-entry output register until the consumer accepts it.
//
// Handshakes: a transfer happens on a clock edge where valid && ready are both high;
// a source holds its payload stable while valid is high and ready is low, and
// in_ready never depends on the same-cycle pop.
//
// Optional feature: define MUL_SEQ_TIMEOUT_EN to abort a multiplication that does not
// complete within TIMEOUT_CYC WAIT cycles. The abort delivers 16'hFFFF with out_err=1.
// Without the macro WAIT holds until mul_done and out_err is tied to 0.
module mul_op_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        in_ready,
    output logic [15:0] mul_data,
    output logic        mul_start,
    input  logic        mul_done,
    input  logic [15:0] mul_product,
    output logic        out_valid,
    output logic [15:0] out_product,
    output logic        out_err,
    input  logic        out_ready,
    output logic [1:0]  o_dbg_state
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD_A = 2'd1,
        S_LOAD_B = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [15:0]   r_op_a;
    logic [15:0]   r_op_b;
    logic          r_out_valid;
    logic [15:0]   r_out_product;
    logic          w_push;
    logic          w_pop;
    logic          w_done;
    logic          w_tmo;

    // Pop only from registered occupancy, so a same-cycle push is never bypassed.
    assign in_ready    = (r_count != DEPTH_C);
    assign w_push      = in_valid && in_ready;
    assign w_pop       = (r_state == S_IDLE) && (r_count != '0) && !r_out_valid;
    assign w_done      = (r_state == S_WAIT) && mul_done;
    assign out_valid   = r_out_valid;
    assign out_product = r_out_product;
    assign o_dbg_state = r_state;

`ifdef MUL_SEQ_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;
    logic       r_out_err;

    // Abort fires on the WAIT cycle in which the count reaches TIMEOUT_CYC.
    assign w_tmo   = (r_state == S_WAIT) && !mul_done && (r_tmo_cnt == 8'(TIMEOUT_CYC - 1));
    assign out_err = r_out_err;

    // Timeout counter: cleared entering WAIT, counts WAIT cycles without completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_LOAD_B) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == S_WAIT) && !mul_done) begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end
    end

    // Error flag travels with the captured result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_err <= 1'b0;
        end else if (w_done) begin
            r_out_err <= 1'b0;
        end else if (w_tmo) begin
            r_out_err <= 1'b1;
        end
    end
`else
    assign w_tmo   = 1'b0;
    assign out_err = 1'b0;
`endif

    // FIFO storage: payload only, no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_a, in_b};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Operand registers capture the head pair on the launch edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a <= '0;
            r_op_b <= '0;
        end else if (w_pop) begin
            r_op_a <= r_mem[r_rd_ptr][31:16];
            r_op_b <= r_mem[r_rd_ptr][15:0];
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and multiplier-side outputs; mul_done only matters in WAIT.
    always_comb begin
        w_next_state = r_state;
        mul_data     = '0;
        mul_start    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pop) w_next_state = S_LOAD_A;
            end
            S_LOAD_A: begin
                mul_data     = r_op_a;
                mul_start    = 1'b1;
                w_next_state = S_LOAD_B;
            end
            S_LOAD_B: begin
                mul_data     = r_op_b;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                mul_data = r_op_b;
                if (mul_done || w_tmo) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Result register: filled on completion or abort, emptied by the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_product <= '0;
        end else if (w_done) begin
            r_out_valid   <= 1'b1;
            r_out_product <= mul_product;
        end else if (w_tmo) begin
            r_out_valid   <= 1'b1;
            r_out_product <= 16'hFFFF;
        end else if (r_out_valid && out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

endmodule
